// File: rtl/strobe_scheduler.sv
// -----------------------------------------------------------------------------
// strobe_scheduler
//
// Multi-channel periodic event scheduler. Each channel counts base ticks from
// the strobe generator down from a programmable interval. On expiry the channel
// raises a pending request. A round-robin arbiter offers pending requests one
// at a time on a valid/ack port.
//
// Ports:
//   Clock          system clock, rising edge
//   Reset          asynchronous reset, active high, clears all state
//   Tick_i         one-cycle base strobe
//   Enable_i       low freezes every counter; arbitration keeps running
//   CfgWrite_i     one-cycle interval write strobe
//   CfgChannel_i   channel addressed by the write
//   CfgInterval_i  interval in ticks, 0 disables the channel
//   Valid_o        an event for Channel_o is offered
//   Channel_o      index of the offered channel, stable while Valid_o is high
//   Ack_i          consumer accepts the offered event
//   Overrun_o      per-channel sticky flag: an event merged into one still pending
// -----------------------------------------------------------------------------
module strobe_scheduler #(
  parameter int CHANNELS       = 4,
  parameter int INTERVAL_WIDTH = 16
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Tick_i,
  input  logic                        Enable_i,
  input  logic                        CfgWrite_i,
  input  logic [$clog2(CHANNELS)-1:0] CfgChannel_i,
  input  logic [INTERVAL_WIDTH-1:0]   CfgInterval_i,
  output logic                        Valid_o,
  output logic [$clog2(CHANNELS)-1:0] Channel_o,
  input  logic                        Ack_i,
  output logic [CHANNELS-1:0]         Overrun_o
);

  localparam int CW = $clog2(CHANNELS);
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

  typedef enum logic {
    ARB_IDLE,
    ARB_OFFER
  } arb_state_t;

  // Per-channel state
  logic [INTERVAL_WIDTH-1:0] interval_q [CHANNELS];
  logic [INTERVAL_WIDTH-1:0] counter_q  [CHANNELS];
  logic [CHANNELS-1:0]       pending_q;
  logic [CHANNELS-1:0]       overrun_q;

  // Arbiter state
  arb_state_t                state_q;
  logic [CW-1:0]             ptr_q;
  logic                      valid_q;
  logic [CW-1:0]             channel_q;

  // Per-cycle decode
  logic [CHANNELS-1:0]       write_hit;
  logic [CHANNELS-1:0]       count_en;
  logic [CHANNELS-1:0]       fire;
  logic [CHANNELS-1:0]       accept_hit;
  logic [CHANNELS-1:0]       eligible;
  logic                      accept;
  logic                      grant_found;
  logic [CW-1:0]             grant_idx;
  logic [CW-1:0]             cand;

  // Ack only means something while an offer is on the port.
  assign accept = valid_q && Ack_i;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    write_hit  = '0;
    count_en   = '0;
    fire       = '0;
    accept_hit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      write_hit[c]  = CfgWrite_i && (CfgChannel_i == CW'(c));
      // A write to the same channel wins over the tick: no decrement, no event.
      count_en[c]   = Tick_i && Enable_i && (interval_q[c] != '0) && !write_hit[c];
      fire[c]       = count_en[c] && (counter_q[c] == INTERVAL_WIDTH'(1));
      accept_hit[c] = accept && (channel_q == CW'(c));
    end
  end

  // A channel being rewritten this cycle has its pending request cleared, so
  // it must not be chosen for a fresh offer on the same edge.
  assign eligible = pending_q & ~write_hit;

  // Round-robin pick: first eligible index at or after ptr_q, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = CW'((int'(ptr_q) + i) % CHANNELS);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Channel counters, pending requests and overrun flags.
  // NOTE: the interval/counter arrays are ordinary flops, not a RAM, so they
  // are reset like any other state; a disabled channel must read 0 after reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        interval_q[c] <= '0;
        counter_q[c]  <= '0;
      end
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // read in this block sees the value from before the edge.
      for (int c = 0; c < CHANNELS; c++) begin
        if (write_hit[c]) begin
          interval_q[c] <= CfgInterval_i;
          counter_q[c]  <= CfgInterval_i;
          pending_q[c]  <= 1'b0;
          overrun_q[c]  <= 1'b0;
        end else begin
          if (count_en[c]) begin
            counter_q[c] <= fire[c] ? interval_q[c]
                                    : counter_q[c] - INTERVAL_WIDTH'(1);
          end
          if (fire[c]) begin
            // An event landing on an accepted request counts as new; only a
            // request still waiting is lost.
            if (pending_q[c] && !accept_hit[c]) begin
              overrun_q[c] <= 1'b1;
            end
            pending_q[c] <= 1'b1;
          end else if (accept_hit[c]) begin
            pending_q[c] <= 1'b0;
          end
        end
      end
    end
  end

  // Arbiter: IDLE picks a pending channel, OFFER holds it until accepted or
  // until the offered channel is reconfigured. Every return to IDLE costs one
  // cycle, which gives the guaranteed gap between acceptances.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      channel_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (grant_found) begin
            state_q   <= ARB_OFFER;
            valid_q   <= 1'b1;
            channel_q <= grant_idx;
            ptr_q     <= (grant_idx == LAST_CH) ? '0 : grant_idx + CW'(1);
          end
        end
        ARB_OFFER: begin
          if (Ack_i || write_hit[channel_q]) begin
            state_q <= ARB_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign Valid_o   = valid_q;
  assign Channel_o = channel_q;
  assign Overrun_o = overrun_q;

endmodule

// File: doc/strobe_scheduler.md
# strobe_scheduler

Multi-channel periodic event scheduler driven by the base tick of the strobe generator. Each channel holds a programmable interval, counted in base ticks; when a channel expires it raises a pending request. Pending requests are arbitrated round-robin onto a single valid/ack output port. Sits between the strobe generator and the consumers that need slower, independently programmed periodic events, such as display refresh, key scan and sensor polling.

## Interface
- CHANNELS, 4, number of channels; legal range is 2..16.
- INTERVAL_WIDTH, 16, width of each interval and counter, in bits.
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous reset, active-high; clears all state.
- Tick_i  in  1  base strobe, one cycle wide, from the strobe generator.
- Enable_i  in  1  while low, all counters freeze; the arbitration and the handshake keep running.
- CfgWrite_i  in  1  one-cycle write strobe for the interval configuration.
- CfgChannel_i  in  $clog2(CHANNELS)  channel selected by the write.
- CfgInterval_i  in  INTERVAL_WIDTH  interval in ticks; 0 disables the channel.
- Valid_o  out  1  an event for Channel_o is being offered.
- Channel_o  out  $clog2(CHANNELS)  index of the channel being offered.
- Ack_i  in  1  consumer accepts the offered event.
- Overrun_o  out  CHANNELS  per-channel sticky flag: an event was lost.

## Operation
- Per-channel state: Interval[c], Counter[c], Pending[c], Overrun[c].
- Rotating pointer: Ptr, of width $clog2(CHANNELS).
- Reset values: all of the per-channel state, Ptr, Valid_o and Channel_o are 0.
- Config write to channel c:
  - Interval[c] <= CfgInterval_i and Counter[c] <= CfgInterval_i.
  - Pending[c] and Overrun[c] are cleared.
  - If c is currently granted, Valid_o drops on the next edge.
- Count condition: on Tick_i && Enable_i, every channel with Interval[c] != 0 and no write this cycle does the following:
  - If Counter[c] == 1, an event fires and Counter[c] <= Interval[c].
  - Otherwise Counter[c] <= Counter[c] - 1.
- Period: an event fires every Interval[c] ticks. The first event after a write comes Interval[c] ticks after the write.
- Event on channel c:
  - Pending[c] <= 1.
  - If Pending[c] was already 1 and is not being acked this cycle, Overrun[c] <= 1. The event merges into the existing pending request.
- A write and a tick on the same channel in the same cycle: the write wins. There is no decrement and no event.
- Arbiter states:
  - IDLE, where Valid_o = 0.
  - OFFER, where Valid_o = 1 and Channel_o is held stable.
- IDLE -> OFFER: taken when any Pending bit is set at the clock edge.
  - Channel_o <= the first pending index at or after Ptr, searching upward modulo CHANNELS.
  - Ptr <= that index + 1, modulo CHANNELS.
- OFFER with Ack_i = 1:
  - Pending[Channel_o] clears, unless a new event for that channel fires in the same cycle; that event counts as new, with no overrun.
  - The arbiter returns to IDLE.
- OFFER with Ack_i = 0: Valid_o and Channel_o hold.
- Ack_i is ignored while Valid_o = 0.
- Overrun_o = Overrun. It is cleared only by reset or by a config write to that channel.

## Timing
- Event latency:
  - Tick at edge N sets Pending at edge N.
  - Valid_o is high after edge N+1, when the arbiter is idle.
- Handshake:
  - An acceptance is Valid_o && Ack_i sampled at a rising edge.
  - Valid_o is low for at least one cycle after each acceptance, so the peak throughput is one event every 2 cycles.
- Config writes take effect at the edge where they are sampled. A write and an Ack_i can coincide on different channels with no interaction.
- Asynchronous reset mid-offer: Valid_o drops immediately, without waiting for a clock edge. All pending events are discarded.
- Enable_i low:
  - Ticks are ignored; a tick does not retroactively count when Enable_i returns high.
  - Pending events are still offered.

## Test plan
- Fixed rate, single channel.
  - Stimulus: write ch0 = 3; tick every 10 cycles; Ack_i tied high.
  - Response: Valid_o with Channel_o = 0 on every 3rd tick, one cycle after that tick, lasting 1 cycle; Overrun_o = 0.
- Round-robin fairness.
  - Stimulus: ch0..3 = 1, Ptr = 0, one tick, Ack_i high.
  - Response: grants 0, 1, 2, 3, on cycles 1, 3, 5, 7 after the tick.
  - Follow-up: repeat with only ch1 and ch3 pending and Ptr = 2. The grant order must be 3, then 1.
- Overrun.
  - Stimulus: ch2 = 1; Ack_i held low across 2 ticks.
  - Response: Valid_o stays high with Channel_o = 2, and Overrun_o[2] = 1.
  - Follow-up: after ack, a write ch2 = 5 clears Overrun_o[2].
- Ack coinciding with a new event.
  - Stimulus: ch1 = 1; Ack_i asserted in the same cycle as the next tick.
  - Response: Pending[1] remains set, Valid_o returns for ch1 after one idle cycle, and Overrun_o[1] = 0.
- Write/tick collision and disable.
  - Stimulus: ch0 = 2 with Counter = 1; write ch0 = 4 in the tick cycle.
  - Response: no event; the next event comes 4 ticks later.
  - Follow-up: write ch0 = 0. Afterwards, no events occur from ch0 for any number of ticks.
- Enable freeze and async reset.
  - Stimulus: Enable_i low for 5 ticks with ch0 = 2.
  - Response: no new events while Enable_i is low. The counter resumes from its frozen value.
  - Follow-up: assert Reset mid-OFFER. Valid_o = 0 immediately, and all Overrun_o bits are 0.
